// File: rtl/ram8_16_pkg.sv
// Shared constants and the 3-to-8 one-hot load decode for the RAM8 register bank.
package ram8_16_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DEPTH         = 8;
  localparam int ADDR_W        = 3;

  // dmux8way-style decode: exactly one load line per address.
  function automatic logic [DEPTH-1:0] decode8(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] onehot;
    onehot    = '0;
    onehot[a] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/ram8_16_mux8way16.sv
// mux8way16: 8:1 combinational read multiplexer for the register bank.
module ram8_16_mux8way16
  import ram8_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] d,
  input  logic [ADDR_W-1:0]           sel,
  output logic [WIDTH-1:0]            y
);

  assign y = d[sel];

endmodule

// File: rtl/ram8_16.sv
// Eight-word register bank with one-hot write decode, combinational read,
// per-word valid flags, bulk clear and a count of valid words.
module ram8_16
  import ram8_16_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              valid,
  output logic              any_valid,
  output logic [3:0]        wr_count
);

  logic [WIDTH-1:0]            word_reg [DEPTH];
  logic [DEPTH-1:0]            valid_reg;
  logic [3:0]                  count_reg;
  logic [3:0]                  count_next;
  logic [DEPTH-1:0]            load_dec;
  logic                        new_word;
  logic                        wr_en;
  logic [DEPTH-1:0][WIDTH-1:0] word_flat;
  logic [WIDTH-1:0]            mux_out;

  assign wr_en    = load && !clear;
  assign load_dec = wr_en ? decode8(address) : '0;
  // Only a first write to a word grows the count, so it tops out at DEPTH.
  assign new_word   = |(load_dec & ~valid_reg);
  assign count_next = count_reg + 4'(new_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) word_reg[i] <= '0;
      valid_reg <= '0;
      count_reg <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) word_reg[i] <= '0;
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load_dec[i]) word_reg[i] <= in;
      end
      valid_reg <= valid_reg | load_dec;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign word_flat[gi] = word_reg[gi];
    end
  endgenerate

  ram8_16_mux8way16 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .d  (word_flat),
    .sel(address),
    .y  (mux_out)
  );

  generate
    if (BYPASS) begin : g_bypass
      // Write-through is suppressed while reset holds the bank at zero.
      logic thru;
      assign thru  = wr_en && rst_n;
      assign out   = thru ? in : mux_out;
      assign valid = thru ? 1'b1 : valid_reg[address];
    end else begin : g_stored
      assign out   = mux_out;
      assign valid = valid_reg[address];
    end
  endgenerate

  assign wr_count  = count_reg;
  assign any_valid = (count_reg != 4'd0);

endmodule

// File: tb/tb_ram8_16.sv
// Scoreboarded bench for ram8_16: stored-read and write-through instances
// compared against an array model of the word bank.
module tb_ram8_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic        clear;

  logic [15:0] out0, out1;
  logic        valid0, valid1, anyv0, anyv1;
  logic [3:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  ram8_16 #(.WIDTH(16), .BYPASS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .address(address),
    .clear(clear), .out(out0), .valid(valid0), .any_valid(anyv0), .wr_count(cnt0)
  );

  ram8_16 #(.WIDTH(16), .BYPASS(1'b1)) dut_bp (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .address(address),
    .clear(clear), .out(out1), .valid(valid1), .any_valid(anyv1), .wr_count(cnt1)
  );

  typedef struct {
    string       tag;
    logic [15:0] out;
    logic        valid;
    logic        anyv;
    logic [3:0]  cnt;
    logic [15:0] bp_out;
    logic        bp_valid;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [8];
  bit          vld [8];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          done  = 0;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (vld[i]) c++;
    return c;
  endfunction

  function automatic exp_t model_out(string tag, logic l, logic c, logic [2:0] a, logic [15:0] d);
    exp_t e;
    bit thru;
    thru       = rst_n && l && !c;
    e.tag      = tag;
    e.out      = rst_n ? mem[a] : 16'h0000;
    e.valid    = rst_n ? vld[a] : 1'b0;
    e.cnt      = rst_n ? 4'(model_count()) : 4'd0;
    e.anyv     = (e.cnt != 0);
    e.bp_out   = thru ? d : e.out;
    e.bp_valid = thru ? 1'b1 : e.valid;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'h0000;
      vld[i] = 0;
    end
  endtask

  task automatic model_edge(logic l, logic c, logic [2:0] a, logic [15:0] d);
    if (!rst_n || c) model_clear();
    else if (l) begin
      mem[a] = d;
      vld[a] = 1;
    end
  endtask

  task automatic apply(string tag, logic l, logic c, logic [2:0] a, logic [15:0] d);
    load    = l;
    clear   = c;
    address = a;
    din     = d;
    sb.push_back(model_out(tag, l, c, a, d));
    @(posedge clk);
    model_edge(l, c, a, d);
    #2;
  endtask

  // Reset is dropped between edges; the check lands on the negedge before any clock.
  task automatic pulse_reset(string tag, logic [2:0] a);
    load    = 1'b0;
    clear   = 1'b0;
    address = a;
    rst_n   = 1'b0;
    model_clear();
    sb.push_back(model_out(tag, 1'b0, 1'b0, a, din));
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic chk16(string tag, string fld, logic [15:0] act, logic [15:0] req);
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s %s actual=%h required=%h", tag, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      chk16(e.tag, "out",       out0,          e.out);
      chk16(e.tag, "valid",     16'(valid0),   16'(e.valid));
      chk16(e.tag, "any_valid", 16'(anyv0),    16'(e.anyv));
      chk16(e.tag, "wr_count",  16'(cnt0),     16'(e.cnt));
      chk16(e.tag, "bp_out",    out1,          e.bp_out);
      chk16(e.tag, "bp_valid",  16'(valid1),   16'(e.bp_valid));
      chk16(e.tag, "bp_count",  16'(cnt1),     16'(e.cnt));
      $display("vec %0d %s addr=%0d out=%h valid=%b cnt=%0d bp_out=%h", n_vec, e.tag,
               address, out0, valid0, cnt0, out1);
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst_n   = 1'b0;
    load    = 1'b1;
    clear   = 1'b0;
    address = 3'd0;
    din     = 16'hFFFF;
    model_clear();
    @(posedge clk);
    #2;
    for (int k = 0; k < 8; k++) apply("reset_hold", 1'b1, 1'b0, 3'(k), 16'hFFFF);
    rst_n = 1'b1;
    apply("reset_release", 1'b0, 1'b0, 3'd0, 16'hFFFF);

    for (int k = 0; k < 8; k++) apply("write_k", 1'b1, 1'b0, 3'(k), 16'(k * 16'h1111));
    apply("read5", 1'b0, 1'b0, 3'd5, 16'h0000);
    apply("read2", 1'b0, 1'b0, 3'd2, 16'h0000);

    apply("rewrite3", 1'b1, 1'b0, 3'd3, 16'hBEEF);
    apply("read3", 1'b0, 1'b0, 3'd3, 16'h0000);
    apply("read4", 1'b0, 1'b0, 3'd4, 16'h0000);

    apply("clear_vs_load", 1'b1, 1'b1, 3'd6, 16'h1234);
    apply("read6", 1'b0, 1'b0, 3'd6, 16'h0000);
    for (int k = 0; k < 8; k++) apply("cleared", 1'b0, 1'b0, 3'(k), 16'h0000);

    apply("bypass1", 1'b1, 1'b0, 3'd1, 16'hA5A5);
    apply("read1", 1'b0, 1'b0, 3'd1, 16'h0000);

    apply("write0", 1'b1, 1'b0, 3'd0, 16'h00FF);
    apply("read0", 1'b0, 1'b0, 3'd0, 16'h0000);
    pulse_reset("async_reset", 3'd0);
    apply("post_reset", 1'b0, 1'b0, 3'd0, 16'h0000);

    for (int n = 0; n < 400; n++) begin
      logic       l, c;
      logic [2:0] a;
      l = ($urandom_range(0, 99) < 55);
      c = ($urandom_range(0, 99) < 4);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_reset", a);
      else apply("random", l, c, a, 16'($urandom));
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram8_16.md
Name: ram8_16

Overview:
- Eight-word × 16-bit register bank (RAM8 stage) that drives the 8:1 16-bit read multiplexer.
- Eight registers are written synchronously via a one-hot load decode of `address`.
- The eight register outputs are selected combinationally by `address` onto `out`.
- Per-word valid flags and a bulk clear support memory-init checks in the CPU datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- BYPASS, 0. When 1, `out` shows `in` during a write to the addressed word (write-through). When 0, `out` shows the stored value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  write data
- load  input  1  write enable for the word at `address`
- address  input  3  word select for both write and read
- clear  input  1  synchronous bulk clear of all words and valid flags
- out  output  WIDTH  read data of word `address`
- valid  output  1  valid flag of word `address`
- any_valid  output  1  OR of all eight valid flags
- wr_count  output  4  number of valid words (0..8)

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - All eight words clear to 16'h0000.
  - All valid flags clear to 0.
  - `wr_count` = 0, so `out` = 0, `valid` = 0, `any_valid` = 0.
  - Deasserting reset is sampled at the next rising clk; the first write can land on that edge.
- Write:
  - On rising clk with load=1 and clear=0, word[address] <= in and valid[address] <= 1.
  - Exactly one word is written per cycle.
  - Zero-cycle write latency to storage; the new value is visible on `out` the cycle after the edge (BYPASS=0).
- Read:
  - Purely combinational: out = word[address], valid = valid[address].
  - No read latency and no handshake.
  - An address change updates `out` in the same cycle.
- Bypass (BYPASS=1):
  - While load=1 and clear=0, out = in and valid = 1 combinationally, before the edge.
  - When load=0, behaviour is identical to BYPASS=0.
- Clear:
  - On rising clk with clear=1, all words go to 0, all valid flags to 0, and wr_count to 0.
  - clear has priority over load when both are asserted in the same cycle; the write is dropped.
- Valid counter (wr_count):
  - Increments by 1 on a write to a word whose valid flag was 0.
  - Unchanged on a rewrite of an already-valid word.
  - Saturates at 8 by construction, since only 8 flags exist; it never wraps.
  - any_valid = (wr_count != 0).
- Width rules:
  - `in` is stored unmodified; there is no sign or zero extension.
  - `address` is 3 bits, fully decoded; there are no out-of-range addresses.
- Load=0 cycles: all state holds.
- Reset mid-write: an asynchronous reset asserted in the same cycle as load wins. Storage is 0 after the edge.

Decomposition:
- Shared package holds:
  - WIDTH default (16),
  - DEPTH=8,
  - ADDR_W=3,
  - the one-hot decode function (dmux8way-style load decode, 3→8).
- Natural sub-module: mux8way16, the 8:1 16-bit combinational read mux selected by `address`.
  - The bank instantiates it once for `out`.
  - The bank uses an 8:1 1-bit selection for `valid`.
- Storage and wr_count logic are kept in ram8_16 itself; no further sub-modules.

Test Plan:
- Reset: hold rst_n=0 with load=1, in=16'hFFFF -> all words 0, wr_count=0, valid=0 for all 8 addresses; release -> still 0 until the first write edge.
- Write/readback: write k*16'h1111 to address k for k=0..7 -> reading address 5 gives 16'h5555, valid=1, wr_count=8, any_valid=1; address change to 2 gives 16'h2222 the same cycle.
- Rewrite: write 16'hBEEF to address 3 after all 8 are valid -> out@3=16'hBEEF, wr_count stays 8, other words unchanged (address 4 still 16'h4444).
- Clear priority: clear=1 and load=1, address=6, in=16'h1234 -> after the edge all words 0, valid=0 everywhere, wr_count=0; address 6 reads 16'h0000.
- Bypass (BYPASS=1): load=1, address=1, in=16'hA5A5 with word1=0 -> out=16'hA5A5 and valid=1 before the edge; BYPASS=0 instance shows 16'h0000 until the edge.
- Async reset mid-operation: write 16'h00FF to address 0, then pulse rst_n low between edges -> out drops to 0 immediately, without waiting for a clk edge.
